// File: rtl/obuft_pkg.sv
// Shared types and sizing helpers for the registered tri-state bus driver bank.
package obuft_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    TURN    = 2'd1,
    DRIVE   = 2'd2,
    RELEASE = 2'd3
  } state_e;

  localparam int TURN_CYC_MAX = 15;

  // Counter must hold TURN_CYC-1 but never collapse to zero bits.
  function automatic int turn_cnt_w(input int turn_cyc);
    return (turn_cyc < 1) ? 1 : $clog2(turn_cyc + 1);
  endfunction

endpackage

// File: rtl/obuft_gts_sync.sv
// Two-flop synchroniser for the asynchronous global-tristate input.
// Resets to 1 so the bus stays released until GTS has been seen low for two edges.
module obuft_gts_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic gts,
  output logic gts_s
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta  <= 1'b1;
      gts_s <= 1'b1;
    end else begin
      meta  <= gts;
      gts_s <= meta;
    end
  end

endmodule

// File: rtl/obuft_bus_driver.sv
// Registered tri-state output bank with request/ack bus ownership, GTS release
// and a programmable number of all-Z turnaround cycles before driving.
//
//   state   | meaning
//   IDLE    | bus released, waiting for drv_req with GTS clear
//   TURN    | dead cycles before first drive, counting turn_cnt down to 0
//   DRIVE   | bus owned: oe_reg=1, ack=1, o_reg follows i every edge
//   RELEASE | one forced Z cycle after driving, then back to IDLE
module obuft_bus_driver
  import obuft_pkg::*;
#(
  parameter int               WIDTH    = 8,
  parameter int               TURN_CYC = 1,
  parameter logic [WIDTH-1:0] INIT_O   = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             gts,
  input  logic             drv_req,
  input  logic [WIDTH-1:0] i,
  output logic             ack,
  output wire  [WIDTH-1:0] o,
  output logic             t_stat
);

  localparam int TURN_EFF = (TURN_CYC > TURN_CYC_MAX) ? TURN_CYC_MAX : TURN_CYC;
  localparam int CNT_W    = turn_cnt_w(TURN_EFF);
  localparam logic [CNT_W-1:0] TURN_INIT = CNT_W'((TURN_EFF > 0) ? TURN_EFF - 1 : 0);

  state_e             state;
  logic               oe_reg;
  logic [WIDTH-1:0]   o_reg;
  logic [CNT_W-1:0]   turn_cnt;
  logic               gts_s;

  obuft_gts_sync u_gts_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .gts   (gts),
    .gts_s (gts_s)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      oe_reg   <= 1'b0;
      o_reg    <= INIT_O;
      ack      <= 1'b0;
      turn_cnt <= '0;
    end else if (gts_s) begin
      // Released bus overrides any request; o_reg keeps its last value.
      state    <= IDLE;
      oe_reg   <= 1'b0;
      ack      <= 1'b0;
      turn_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          oe_reg <= 1'b0;
          ack    <= 1'b0;
          if (drv_req) begin
            if (TURN_EFF == 0) begin
              state  <= DRIVE;
              oe_reg <= 1'b1;
              ack    <= 1'b1;
              o_reg  <= i;
            end else begin
              state    <= TURN;
              turn_cnt <= TURN_INIT;
            end
          end
        end
        TURN: begin
          oe_reg <= 1'b0;
          ack    <= 1'b0;
          if (!drv_req) begin
            state    <= IDLE;
            turn_cnt <= '0;
          end else if (turn_cnt == '0) begin
            state  <= DRIVE;
            oe_reg <= 1'b1;
            ack    <= 1'b1;
            o_reg  <= i;
          end else begin
            turn_cnt <= turn_cnt - 1'b1;
          end
        end
        DRIVE: begin
          if (drv_req) begin
            oe_reg <= 1'b1;
            ack    <= 1'b1;
            o_reg  <= i;
          end else begin
            state  <= RELEASE;
            oe_reg <= 1'b0;
            ack    <= 1'b0;
          end
        end
        RELEASE: begin
          // A request seen here is deliberately ignored: no back-to-back drive.
          state  <= IDLE;
          oe_reg <= 1'b0;
          ack    <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          oe_reg   <= 1'b0;
          ack      <= 1'b0;
          turn_cnt <= '0;
        end
      endcase
    end
  end

  // Raw GTS gates the pads directly so release needs no clock edge.
  assign t_stat = ~oe_reg | gts;

  for (genvar b = 0; b < WIDTH; b++) begin : g_pad
    assign o[b] = t_stat ? 1'bz : o_reg[b];
  end

endmodule

// File: tb/tb_obuft_bus_driver.sv
// Directed bench for obuft_bus_driver: main bank (TURN_CYC=1) plus TURN_CYC=0/3 banks.
// Pads are pulled down, so a released bus reads as all zeros.
module tb_obuft_bus_driver;
  import obuft_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       gts = 1'b0;
  logic       drv_req = 1'b0;
  logic [7:0] din = 8'h00;

  wire [7:0] bus_m;
  wire [3:0] bus_0;
  wire [3:0] bus_3;
  logic      ack_m, ack_0, ack_3;
  logic      ts_m, ts_0, ts_3;

  int vectors = 0;
  int miscompares = 0;

  for (genvar g = 0; g < 8; g++) begin : g_pd_m
    pulldown (bus_m[g]);
  end
  for (genvar g = 0; g < 4; g++) begin : g_pd_s
    pulldown (bus_0[g]);
    pulldown (bus_3[g]);
  end

  obuft_bus_driver #(.WIDTH(8), .TURN_CYC(1), .INIT_O(8'h3C)) dut (
    .clk(clk), .rst_n(rst_n), .gts(gts), .drv_req(drv_req), .i(din),
    .ack(ack_m), .o(bus_m), .t_stat(ts_m)
  );

  obuft_bus_driver #(.WIDTH(4), .TURN_CYC(0), .INIT_O(4'h9)) dut0 (
    .clk(clk), .rst_n(rst_n), .gts(gts), .drv_req(drv_req), .i(din[3:0]),
    .ack(ack_0), .o(bus_0), .t_stat(ts_0)
  );

  obuft_bus_driver #(.WIDTH(4), .TURN_CYC(3), .INIT_O(4'h9)) dut3 (
    .clk(clk), .rst_n(rst_n), .gts(gts), .drv_req(drv_req), .i(din[3:0]),
    .ack(ack_3), .o(bus_3), .t_stat(ts_3)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #12;
    vectors++;
    if (ack_m !== 1'b0) begin miscompares++; $display("FAIL rst_ack got %b want 0", ack_m); end
    vectors++;
    if (ts_m !== 1'b1) begin miscompares++; $display("FAIL rst_tstat got %b want 1", ts_m); end
    vectors++;
    if (bus_m !== 8'h00) begin miscompares++; $display("FAIL rst_bus got %h want Z(00)", bus_m); end
    vectors++;
    if (dut.o_reg !== 8'h3C) begin miscompares++; $display("FAIL rst_oreg got %h want 3c", dut.o_reg); end
    rst_n = 1'b1;
    tick();
    tick();
    tick();
    vectors++;
    if (dut.state !== IDLE) begin miscompares++; $display("FAIL rst_idle got %0d want IDLE", dut.state); end
    vectors++;
    if (ts_m !== 1'b1) begin miscompares++; $display("FAIL rst_idle_tstat got %b want 1", ts_m); end
  endtask

  task automatic test_first_drive();
    drv_req = 1'b1;
    din = 8'hA5;
    tick();
    vectors++;
    if (bus_m !== 8'h00 || ack_m !== 1'b0 || ts_m !== 1'b1) begin
      miscompares++;
      $display("FAIL turn_cycle got bus=%h ack=%b t=%b want bus=Z ack=0 t=1", bus_m, ack_m, ts_m);
    end
    tick();
    vectors++;
    if (bus_m !== 8'hA5 || ack_m !== 1'b1 || ts_m !== 1'b0) begin
      miscompares++;
      $display("FAIL first_drive got bus=%h ack=%b t=%b want bus=a5 ack=1 t=0", bus_m, ack_m, ts_m);
    end
  endtask

  task automatic test_stream();
    logic [7:0] seq [3];
    seq[0] = 8'h11; seq[1] = 8'h22; seq[2] = 8'h33;
    for (int k = 0; k < 3; k++) begin
      din = seq[k];
      tick();
      vectors++;
      if (bus_m !== seq[k] || ack_m !== 1'b1) begin
        miscompares++;
        $display("FAIL stream%0d got bus=%h ack=%b want bus=%h ack=1", k, bus_m, ack_m, seq[k]);
      end
    end
    drv_req = 1'b0;
    tick();
    vectors++;
    if (bus_m !== 8'h00 || ack_m !== 1'b0 || dut.state !== RELEASE) begin
      miscompares++;
      $display("FAIL release got bus=%h ack=%b st=%0d want Z,0,RELEASE", bus_m, ack_m, dut.state);
    end
    tick();
    vectors++;
    if (bus_m !== 8'h00 || dut.state !== IDLE) begin
      miscompares++;
      $display("FAIL post_release got bus=%h st=%0d want Z,IDLE", bus_m, dut.state);
    end
  endtask

  task automatic test_gts();
    drv_req = 1'b1;
    din = 8'h5A;
    tick();
    tick();
    vectors++;
    if (bus_m !== 8'h5A) begin miscompares++; $display("FAIL gts_pre got %h want 5a", bus_m); end
    gts = 1'b1;
    #1;
    vectors++;
    if (bus_m !== 8'h00 || ts_m !== 1'b1) begin
      miscompares++;
      $display("FAIL gts_async got bus=%h t=%b want Z,1", bus_m, ts_m);
    end
    tick();
    tick();
    tick();
    vectors++;
    if (ack_m !== 1'b0 || dut.state !== IDLE || bus_m !== 8'h00) begin
      miscompares++;
      $display("FAIL gts_idle got ack=%b st=%0d bus=%h want 0,IDLE,Z", ack_m, dut.state, bus_m);
    end
    gts = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      tick();
      vectors++;
      if (ack_m !== 1'b0 || bus_m !== 8'h00) begin
        miscompares++;
        $display("FAIL gts_hold%0d got ack=%b bus=%h want 0,Z", k, ack_m, bus_m);
      end
    end
    tick();
    vectors++;
    if (ack_m !== 1'b1 || bus_m !== 8'h5A) begin
      miscompares++;
      $display("FAIL gts_redrive got ack=%b bus=%h want 1,5a", ack_m, bus_m);
    end
  endtask

  task automatic test_turn_latency();
    int lat_m = 0, lat_0 = 0, lat_3 = 0;
    drv_req = 1'b0;
    tick();
    tick();
    tick();
    drv_req = 1'b1;
    din = 8'h96;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (lat_m == 0 && ack_m) lat_m = k;
      if (lat_0 == 0 && ack_0) lat_0 = k;
      if (lat_3 == 0 && ack_3) begin
        lat_3 = k;
        vectors++;
        if (bus_3 !== 4'h6 || ts_3 !== 1'b0) begin
          miscompares++;
          $display("FAIL lat3_data got bus=%h t=%b want 6,0", bus_3, ts_3);
        end
      end
    end
    vectors++;
    if (lat_0 != 1) begin miscompares++; $display("FAIL lat_turn0 got %0d want 1", lat_0); end
    vectors++;
    if (lat_m != 2) begin miscompares++; $display("FAIL lat_turn1 got %0d want 2", lat_m); end
    vectors++;
    if (lat_3 != 4) begin miscompares++; $display("FAIL lat_turn3 got %0d want 4", lat_3); end
  endtask

  task automatic test_reset_mid_drive();
    din = 8'hFF;
    tick();
    vectors++;
    if (bus_m !== 8'hFF) begin miscompares++; $display("FAIL ff_drive got %h want ff", bus_m); end
    rst_n = 1'b0;
    #1;
    vectors++;
    if (bus_m !== 8'h00 || ack_m !== 1'b0 || ts_m !== 1'b1) begin
      miscompares++;
      $display("FAIL async_rst got bus=%h ack=%b t=%b want Z,0,1", bus_m, ack_m, ts_m);
    end
    vectors++;
    if (dut.o_reg !== 8'h3C) begin miscompares++; $display("FAIL rst_init got %h want 3c", dut.o_reg); end
    #2;
    rst_n = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      tick();
      vectors++;
      if (bus_m !== 8'h00 || ack_m !== 1'b0) begin
        miscompares++;
        $display("FAIL rst_sync%0d got bus=%h ack=%b want Z,0", k, bus_m, ack_m);
      end
    end
    vectors++;
    if (dut.o_reg !== 8'h3C) begin miscompares++; $display("FAIL oreg_hold got %h want 3c", dut.o_reg); end
    tick();
    vectors++;
    if (bus_m !== 8'hFF || ack_m !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_redrive got bus=%h ack=%b want ff,1", bus_m, ack_m);
    end
  endtask

  task automatic test_back_to_back();
    int gap_m = 0, gap_0 = 0, gap_3 = 0;
    bit done_m = 0, done_0 = 0, done_3 = 0;
    din = 8'hC7;
    for (int k = 0; k < 4; k++) tick();
    drv_req = 1'b0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (k == 0) begin
        drv_req = 1'b1;
        vectors++;
        if (bus_m !== 8'h00 || ts_m !== 1'b1) begin
          miscompares++;
          $display("FAIL b2b_release got bus=%h t=%b want Z,1", bus_m, ts_m);
        end
      end
      if (!done_m) begin if (ack_m) done_m = 1; else gap_m++; end
      if (!done_0) begin if (ack_0) done_0 = 1; else gap_0++; end
      if (!done_3) begin if (ack_3) done_3 = 1; else gap_3++; end
    end
    vectors++;
    if (gap_m != 3) begin miscompares++; $display("FAIL b2b_gap_turn1 got %0d want 3", gap_m); end
    vectors++;
    if (gap_0 != 2) begin miscompares++; $display("FAIL b2b_gap_turn0 got %0d want 2", gap_0); end
    vectors++;
    if (gap_3 != 5) begin miscompares++; $display("FAIL b2b_gap_turn3 got %0d want 5", gap_3); end
    vectors++;
    if (bus_m !== 8'hC7 || ts_0 !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_redrive got bus=%h t0=%b want c7,0", bus_m, ts_0);
    end
  endtask

  initial begin
    test_reset();
    test_first_drive();
    test_stream();
    test_gts();
    test_turn_latency();
    test_reset_mid_drive();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog bench did not finish in 50000 time units");
    $fatal(1);
  end

endmodule
